// File: rtl/i2c_target_axis_if.sv
// Byte-wide AXI-Stream link used for both directions of the I2C target.
// The master side owns tdata/tvalid and the slave side owns tready.
interface i2c_target_axis_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/i2c_target_axis.sv
// I2C target endpoint oversampling SCL/SDA on clk_i.
// Master writes go out on m_axis; master reads are fed from s_axis.
//
// state    | meaning
// IDLE     | bus free or not yet addressed
// ADDR     | shifting in address + R/W
// ADDR_ACK | driving ACK for a matching address
// WR_DATA  | shifting in a write byte
// WR_ACK   | driving ACK (or NACK on overflow) for a write byte
// RD_DATA  | driving a read byte MSB first
// RD_ACK   | sampling the master's ACK/NACK
// IGNORE   | not ours or read finished; wait for START/STOP
module i2c_target_axis #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2,
  parameter int         DATA_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe_o,
  i2c_target_axis_if.master     m_axis,
  i2c_target_axis_if.slave      s_axis,
  output logic                  busy_o,
  output logic                  stop_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t                 state;
  logic [2:0]             bit_cnt;
  logic [DATA_WIDTH-2:0]  shreg;
  logic                   rw;
  logic                   phase;
  logic                   ack_ok;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      rw            <= 1'b0;
      phase         <= 1'b0;
      ack_ok        <= 1'b0;
      sda_oe_o      <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      s_axis.tready <= 1'b0;
      busy_o        <= 1'b0;
      stop_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      stop_o        <= 1'b0;
      err_o         <= 1'b0;
      s_axis.tready <= 1'b0;
      if (m_axis.tvalid && m_axis.tready)
        m_axis.tvalid <= 1'b0;

      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        sda_oe_o <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
        stop_o   <= busy_o;
      end else begin
        case (state)
          IDLE, IGNORE: ;
          ADDR: if (scl_rise) begin
            shreg   <= {shreg[DATA_WIDTH-3:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw    <= sda_s;
              phase <= 1'b0;
              if (shreg == TARGET_ADDR) begin
                state  <= ADDR_ACK;
                busy_o <= 1'b1;
              end else begin
                state  <= IGNORE;
                busy_o <= 1'b0;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (!phase) begin
              sda_oe_o <= 1'b1;
              phase    <= 1'b1;
            end else begin
              phase   <= 1'b0;
              bit_cnt <= '0;
              if (rw) begin
                state <= RD_DATA;
                if (s_axis.tvalid) begin
                  shreg         <= s_axis.tdata[DATA_WIDTH-2:0];
                  sda_oe_o      <= ~s_axis.tdata[DATA_WIDTH-1];
                  s_axis.tready <= 1'b1;
                end else begin
                  shreg    <= '1;
                  sda_oe_o <= 1'b0;
                  err_o    <= 1'b1;
                end
              end else begin
                state    <= WR_DATA;
                sda_oe_o <= 1'b0;
              end
            end
          end
          WR_DATA: if (scl_rise) begin
            shreg   <= {shreg[DATA_WIDTH-3:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= WR_ACK;
              phase <= 1'b0;
              // a byte still waiting downstream is never overwritten
              if (!m_axis.tvalid || m_axis.tready) begin
                m_axis.tdata  <= {shreg, sda_s};
                m_axis.tvalid <= 1'b1;
                ack_ok        <= 1'b1;
              end else begin
                err_o  <= 1'b1;
                ack_ok <= 1'b0;
              end
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!phase) begin
              sda_oe_o <= ack_ok;
              phase    <= 1'b1;
            end else begin
              sda_oe_o <= 1'b0;
              phase    <= 1'b0;
              bit_cnt  <= '0;
              state    <= WR_DATA;
            end
          end
          RD_DATA: if (scl_fall) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              sda_oe_o <= 1'b0;
              phase    <= 1'b0;
              state    <= RD_ACK;
            end else begin
              sda_oe_o <= ~shreg[DATA_WIDTH-2];
              shreg    <= {shreg[DATA_WIDTH-3:0], 1'b1};
            end
          end
          RD_ACK: if (scl_rise) begin
            if (sda_s) begin
              state  <= IGNORE;
              busy_o <= 1'b0;
            end else begin
              phase <= 1'b1;
            end
          end else if (scl_fall && phase) begin
            phase   <= 1'b0;
            bit_cnt <= '0;
            state   <= RD_DATA;
            if (s_axis.tvalid) begin
              shreg         <= s_axis.tdata[DATA_WIDTH-2:0];
              sda_oe_o      <= ~s_axis.tdata[DATA_WIDTH-1];
              s_axis.tready <= 1'b1;
            end else begin
              shreg    <= '1;
              sda_oe_o <= 1'b0;
              err_o    <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
